// File: rtl/p09_breakout_pkg.sv
// Shared breakout constants: screen and paddle geometry, paddle FSM encoding
// and the speed width used by the paddle controller.
package p09_breakout_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SEG_W     = 8;
    localparam int SEG_COUNT = 6;
    localparam int PADDLE_W  = SEG_W * SEG_COUNT;

    localparam int SPEED_W = 4;

    // Rightmost legal left edge, and the midpoint of the legal range.
    localparam logic [9:0] X_MAX_DEFAULT    = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0] X_CENTER_DEFAULT = 10'((SCREEN_W - PADDLE_W) / 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2
    } paddle_state_t;

endpackage

// File: rtl/p09_sync2.sv
// Two-flop synchroniser for a raw asynchronous level input.
module p09_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/p09_paddle_controller.sv
// Breakout paddle position sequencer: one position update per frame tick,
// press-and-hold acceleration, clamped to [X_MIN, X_MAX].
//
// Handshake note: there is no valid/ready traffic here. recenter is a
// single-cycle request that is latched until the next frame tick; frame_start
// is a level whose rising edge is the only event that advances any state.
module p09_paddle_controller
    import p09_breakout_pkg::*;
#(
    parameter logic [9:0] X_MIN        = 10'd0,
    parameter logic [9:0] X_MAX        = X_MAX_DEFAULT,
    parameter logic [9:0] X_CENTER     = X_CENTER_DEFAULT,
    parameter logic [3:0] SPEED_MIN    = 4'd1,
    parameter logic [3:0] SPEED_MAX    = 4'd8,
    parameter logic [3:0] ACCEL_FRAMES = 4'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               recenter,
    input  logic               frame_start,
    output logic [9:0]         x,
    output logic [SPEED_W-1:0] speed,
    output logic               moving,
    output logic               at_left,
    output logic               at_right
);

    paddle_state_t      state, state_n;
    logic [9:0]         x_n;
    logic [SPEED_W-1:0] speed_n;
    logic [3:0]         accel_cnt, accel_cnt_n, accel_cnt_inc;
    logic               bl, br;
    logic               frame_start_d;
    logic               recenter_pend;
    logic               tick;
    logic               recenter_now;
    logic               want_l, want_r;
    logic [SPEED_W-1:0] step;
    logic [10:0]        x_wide, step_wide;

    p09_sync2 u_sync_left  (.clk(clk), .rst(rst), .d(btn_left),  .q(bl));
    p09_sync2 u_sync_right (.clk(clk), .rst(rst), .d(btn_right), .q(br));

    assign tick         = frame_start & ~frame_start_d;
    assign recenter_now = recenter_pend | recenter;
    // Both buttons together count as no request.
    assign want_l       = bl & ~br;
    assign want_r       = br & ~bl;

    // State register plus position/speed registers, all gated by the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            x             <= X_CENTER;
            speed         <= '0;
            accel_cnt     <= '0;
            frame_start_d <= 1'b0;
            recenter_pend <= 1'b0;
        end else begin
            frame_start_d <= frame_start;
            if (tick) begin
                recenter_pend <= 1'b0;
                state         <= state_n;
                x             <= x_n;
                speed         <= speed_n;
                accel_cnt     <= accel_cnt_n;
            end else if (recenter) begin
                recenter_pend <= 1'b1;
            end
        end
    end

    // Next-state decision; a pending recenter overrides the buttons.
    always_comb begin
        state_n = state;
        if (recenter_now) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_n = want_l ? ST_MOVE_L : (want_r ? ST_MOVE_R : ST_IDLE);
                ST_MOVE_L: state_n = want_l ? ST_MOVE_L : (want_r ? ST_MOVE_R : ST_IDLE);
                ST_MOVE_R: state_n = want_r ? ST_MOVE_R : (want_l ? ST_MOVE_L : ST_IDLE);
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Speed, acceleration counter and clamped position for the chosen state.
    // The counter runs modulo ACCEL_FRAMES; each time it lands on the last
    // value the speed steps up, so every speed lasts ACCEL_FRAMES frames.
    always_comb begin
        speed_n       = '0;
        accel_cnt_n   = '0;
        step          = '0;
        x_n           = x;
        accel_cnt_inc = (accel_cnt == ACCEL_FRAMES - 4'd1) ? 4'd0 : accel_cnt + 4'd1;
        if (recenter_now) begin
            x_n = X_CENTER;
        end else if (state_n != ST_IDLE) begin
            if (state_n != state) begin
                // Entry from IDLE or by reversal restarts the ramp.
                step        = SPEED_MIN;
                speed_n     = SPEED_MIN;
                accel_cnt_n = '0;
            end else begin
                // The step applied now is the old speed; a raise shows next tick.
                step        = speed;
                accel_cnt_n = accel_cnt_inc;
                speed_n     = speed;
                if (accel_cnt_inc == ACCEL_FRAMES - 4'd1 && speed < SPEED_MAX)
                    speed_n = speed + 4'd1;
            end
        end
        x_wide    = {1'b0, x};
        step_wide = 11'(step);
        if (!recenter_now && state_n == ST_MOVE_L)
            x_n = (x_wide < {1'b0, X_MIN} + step_wide) ? X_MIN : 10'(x_wide - step_wide);
        else if (!recenter_now && state_n == ST_MOVE_R)
            x_n = (x_wide + step_wide > {1'b0, X_MAX}) ? X_MAX : 10'(x_wide + step_wide);
    end

    // Status outputs decoded from registered state and position.
    always_comb begin
        moving   = (state != ST_IDLE);
        at_left  = (x == X_MIN);
        at_right = (x == X_MAX);
    end

endmodule

// File: tb/tb_p09_paddle_controller.sv
// Directed bench for the paddle controller: a vector table for the
// acceleration ramp and simple presses, then hand-written multi-frame sequences.
module tb_p09_paddle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_left, btn_right, recenter, frame_start;
    logic [9:0] x;
    logic [3:0] speed;
    logic       moving, at_left, at_right;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       bl;
        logic       br;
        logic [9:0] exp_x;
        logic [3:0] exp_speed;
        logic       exp_moving;
    } vec_t;

    vec_t vecs[16];

    p09_paddle_controller dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .recenter(recenter), .frame_start(frame_start), .x(x), .speed(speed),
        .moving(moving), .at_left(at_left), .at_right(at_right)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int ex, input int es, input int em);
        check({name, " x"}, int'(x), ex);
        check({name, " speed"}, int'(speed), es);
        check({name, " moving"}, int'(moving), em);
        check({name, " at_left"}, int'(at_left), int'(ex == 0));
        check({name, " at_right"}, int'(at_right), int'(ex == 592));
    endtask

    // Buttons settle through the synchroniser before the next tick.
    task automatic set_btn(input logic l, input logic r);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        repeat (3) @(negedge clk);
    endtask

    // One frame_start pulse; outputs are settled when this returns.
    task automatic tick();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_recenter();
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset
        rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
        recenter = 1'b0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 296, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp from centre, then short presses, reversal into idle, both buttons.
        vecs[0]  = '{1'b0, 1'b1, 10'd297, 4'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 10'd298, 4'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 10'd299, 4'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 10'd300, 4'd2, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 10'd302, 4'd2, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 10'd304, 4'd2, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 10'd306, 4'd2, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 10'd308, 4'd3, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 10'd311, 4'd3, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 10'd314, 4'd3, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 10'd314, 4'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 10'd315, 4'd1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 10'd315, 4'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 10'd314, 4'd1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 10'd314, 4'd0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 10'd314, 4'd0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            set_btn(vecs[i].bl, vecs[i].br);
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_x),
                      int'(vecs[i].exp_speed), int'(vecs[i].exp_moving));
        end

        // Reach speed 5 moving right, reverse, then both buttons.
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick();
        check_all("ramp16", 354, 5, 1);
        set_btn(1'b1, 1'b0);
        tick();
        check_all("reversal", 353, 1, 1);
        set_btn(1'b1, 1'b1);
        tick();
        check_all("both", 353, 0, 0);

        // frame_start held high gives a single move.
        set_btn(1'b0, 1'b1);
        @(negedge clk);
        frame_start = 1'b1;
        repeat (100) @(negedge clk);
        check_all("held_fs", 354, 1, 1);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_all("held_fs_after", 354, 1, 1);

        // Button activity between ticks changes nothing.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
        end
        repeat (3) @(negedge clk);
        check_all("no_tick_toggle", 354, 1, 1);
        set_btn(1'b0, 1'b0);
        tick();
        check_all("idle_354", 354, 0, 0);

        // Recenter while moving fast with right held.
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 28; i++) tick();
        check_all("ramp28", 466, 8, 1);
        pulse_recenter();
        repeat (5) @(negedge clk);
        check_all("recenter_pending", 466, 8, 1);
        tick();
        check_all("recenter_tick", 296, 0, 0);
        tick();
        check_all("after_recenter", 297, 1, 1);

        // Recenter arriving in the same cycle as the tick.
        @(negedge clk);
        recenter    = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        recenter    = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_all("recenter_same_cycle", 296, 0, 0);

        // Right clamp: idle at 297, then hold right until the wall.
        tick();
        check_all("pos297", 297, 1, 1);
        set_btn(1'b0, 1'b0);
        tick();
        set_btn(1'b0, 1'b1);
        for (int i = 1; i <= 52; i++) begin
            tick();
            if (i == 50) check_all("right_t50", 585, 8, 1);
            if (i == 51) check_all("right_clamp", 592, 8, 1);
        end
        check_all("right_hold", 592, 8, 1);
        set_btn(1'b0, 1'b0);
        tick();
        check_all("right_release", 592, 0, 0);

        // Left clamp: idle at 295, then hold left until the wall.
        pulse_recenter();
        tick();
        check_all("recenter_from_right", 296, 0, 0);
        set_btn(1'b1, 1'b0);
        tick();
        set_btn(1'b0, 1'b0);
        tick();
        check_all("pos295", 295, 0, 0);
        set_btn(1'b1, 1'b0);
        for (int i = 1; i <= 52; i++) begin
            tick();
            if (i == 50) check_all("left_t50", 7, 8, 1);
            if (i == 51) check_all("left_clamp", 0, 8, 1);
        end
        check_all("left_hold", 0, 8, 1);

        // Asynchronous reset mid-move, checked before any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all("async_reset", 296, 0, 0);
        btn_left = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tick();
        check_all("post_reset_idle", 296, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
